// File: rtl/arm_memory_mp_pkg.sv
// Shared types and helpers for the multi-port ARM word memory.
// Holds the FSM encoding, word geometry and byte-to-word address helper.
package arm_mem_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_AW         = 64;

    function automatic logic [MAX_AW-1:0] word_index(
        input logic [MAX_AW-1:0] a
    );
        return a >> 2;
    endfunction

endpackage

// File: rtl/arm_memory_mp_if.sv
// Request/response bundle for all ports of arm_memory_mp.
// Per-port fields are packed side by side, port p in slice p.
interface arm_memory_mp_if
    import arm_mem_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int ADDR_W = 32
);

    logic                               ready;
    logic [NPORTS*ADDR_W-1:0]           addr;
    logic [NPORTS*WORD_W-1:0]           data_in;
    logic [NPORTS-1:0]                  we;
    logic [NPORTS*BYTES_PER_WORD-1:0]   be;
    logic [NPORTS-1:0]                  re;
    logic [NPORTS-1:0]                  excpt;
    logic [NPORTS*WORD_W-1:0]           data_out;
    logic [NPORTS-1:0]                  valid;

    modport master (
        output addr, data_in, we, be, re,
        input  ready, excpt, data_out, valid
    );

    modport slave (
        input  addr, data_in, we, be, re,
        output ready, excpt, data_out, valid
    );

endinterface

// File: rtl/arm_memory_mp_port_check.sv
// Per-port request screening: alignment and range against DEPTH.
// The index is compared at full width so high address bits never alias.
module arm_mem_port_check
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int CW     = 10
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              accept,
    output logic [CW-1:0]     widx
);

    logic [MAX_AW-1:0] wi;

    assign wi     = word_index(MAX_AW'(addr));
    assign accept = (addr[1:0] == 2'b00)
                 && (wi < MAX_AW'(DEPTH));
    assign widx   = wi[CW-1:0];

endmodule

// File: rtl/arm_memory_mp.sv
// N-port word memory with byte-lane writes, registered reads,
// per-port exceptions and a post-reset clear sweep.
module arm_memory_mp
    import arm_mem_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    arm_memory_mp_if.slave  bus
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     clear_ptr;
    logic              last_clr;
    logic              run;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [NPORTS-1:0] acc;
    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] do_rd;
    logic [NPORTS-1:0] do_wr;
    logic [NPORTS-1:0] bad;
    logic [CW-1:0]     widx [NPORTS];

    for (genvar p = 0; p < NPORTS; p++) begin : g_chk
        arm_mem_port_check #(
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .CW     (CW)
        ) u_chk (
            .addr   (bus.addr[p*ADDR_W +: ADDR_W]),
            .accept (acc[p]),
            .widx   (widx[p])
        );
    end

    assign run      = (state == ST_RUN);
    assign last_clr = (clear_ptr == CW'(DEPTH - 1));
    assign req      = bus.re | bus.we;
    assign do_rd    = {NPORTS{run}} & acc & bus.re;
    assign do_wr    = {NPORTS{run}} & acc & bus.we;
    assign bad      = {NPORTS{run}} & req & ~acc;
    assign bus.ready = run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            (state == ST_INIT): begin
                if (last_clr) state_nx = ST_RUN;
            end
            (state == ST_RUN): state_nx = ST_RUN;
            default: state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            clear_ptr <= '0;
        else if (state == ST_INIT && !last_clr)
            clear_ptr <= clear_ptr + 1'b1;
    end

    // Highest port applied first so the lowest port's byte lands last.
    always_ff @(posedge clk) begin
        if (state == ST_INIT)
            mem[clear_ptr] <= '0;
        for (int p = NPORTS - 1; p >= 0; p--) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (do_wr[p] && bus.be[p*BYTES_PER_WORD + b])
                    mem[widx[p]][b*8 +: 8] <=
                        bus.data_in[p*WORD_W + b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.valid    <= '0;
            bus.excpt    <= '0;
            bus.data_out <= '0;
        end else begin
            bus.valid <= do_rd;
            bus.excpt <= bad;
            for (int p = 0; p < NPORTS; p++) begin
                if (do_rd[p])
                    bus.data_out[p*WORD_W +: WORD_W] <= mem[widx[p]];
            end
        end
    end

endmodule
